// File: rtl/strided_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : strided_addr_gen                                              |
// | Brief  : 2-D strided address generator. Walks row_count x col_count    |
// |          addresses (base + r*row_stride + c*col_stride, mod 2^AW) and  |
// |          streams them over a valid/ready port, flagging the last      |
// |          address and pulsing done at the end of each tile.            |
// |          Optional bounds checking: STRIDED_ADDR_GEN_BOUND_CHECK_EN     |
// |          adds limit_addr / bound_err.                                  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module strided_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] col_stride,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  input  logic [CNT_WIDTH-1:0]  col_count,
  input  logic [CNT_WIDTH-1:0]  row_count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
  ,
  input  logic [ADDR_WIDTH-1:0] limit_addr,
  output logic                  bound_err
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] col_stride_q, col_stride_d;
  logic [ADDR_WIDTH-1:0] row_stride_q, row_stride_d;
  logic [CNT_WIDTH-1:0]  col_count_q, col_count_d;
  logic [CNT_WIDTH-1:0]  row_count_q, row_count_d;
  logic [CNT_WIDTH-1:0]  r_q, r_d;
  logic [CNT_WIDTH-1:0]  c_q, c_d;

  logic                  xfer;
  logic                  col_end;
  logic                  at_last;
  logic                  cfg_nonzero;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  start_oob;
  logic                  next_oob;

`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
  logic [ADDR_WIDTH-1:0] limit_q, limit_d;
  logic                  bound_err_q, bound_err_d;
`endif

  // Handshake and position decode for the address currently presented.
  always_comb begin
    xfer        = addr_valid_q && addr_ready;
    col_end     = (c_q == (col_count_q - CNT_ONE));
    at_last     = col_end && (r_q == (row_count_q - CNT_ONE));
    cfg_nonzero = (col_count != CNT_ZERO) && (row_count != CNT_ZERO);
    // End of a row restarts from the next row base; otherwise step one column.
    next_addr   = col_end ? (row_base_q + row_stride_q) : (addr_q + col_stride_q);
  end

`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
  // Out-of-range tests for the first address of a tile and the next address.
  always_comb begin
    start_oob = (base_addr > limit_addr);
    next_oob  = (next_addr > limit_q);
  end
`else
  // Bounds checking not built: nothing is ever out of range.
  always_comb begin
    start_oob = 1'b0;
    next_oob  = 1'b0;
  end
`endif

  // Next-state logic for the tile walker.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    done_d       = 1'b0;
    row_base_d   = row_base_q;
    col_stride_d = col_stride_q;
    row_stride_d = row_stride_q;
    col_count_d  = col_count_q;
    row_count_d  = row_count_q;
    r_d          = r_q;
    c_d          = c_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!cfg_nonzero) begin
            // Empty tile: nothing to emit, report completion straight away.
            done_d = 1'b1;
          end else begin
            row_base_d   = base_addr;
            col_stride_d = col_stride;
            row_stride_d = row_stride;
            col_count_d  = col_count;
            row_count_d  = row_count;
            r_d          = CNT_ZERO;
            c_d          = CNT_ZERO;
            if (!start_oob) begin
              state_d      = S_RUN;
              addr_d       = base_addr;
              addr_valid_d = 1'b1;
            end
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (at_last) begin
            // Tile finished; addr keeps the final value for observability.
            state_d      = S_IDLE;
            addr_valid_d = 1'b0;
            done_d       = 1'b1;
          end else if (next_oob) begin
            // Refuse to present an address past the limit; abort silently.
            state_d      = S_IDLE;
            addr_valid_d = 1'b0;
          end else begin
            addr_d = next_addr;
            if (col_end) begin
              c_d        = CNT_ZERO;
              r_d        = r_q + CNT_ONE;
              row_base_d = next_addr;
            end else begin
              c_d = c_q + CNT_ONE;
            end
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        addr_valid_d = 1'b0;
      end
    endcase
  end

`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
  // Limit capture on accepted start and one-cycle error pulse on violation.
  always_comb begin
    limit_d     = (state_q == S_IDLE && start && cfg_nonzero) ? limit_addr : limit_q;
    bound_err_d = (state_q == S_IDLE && start && cfg_nonzero && start_oob) ||
                  (state_q == S_RUN && xfer && !at_last && next_oob);
  end

  // Bounds-check registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q     <= '0;
      bound_err_q <= 1'b0;
    end else begin
      limit_q     <= limit_d;
      bound_err_q <= bound_err_d;
    end
  end

  assign bound_err = bound_err_q;
`endif

  // State, address and latched configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      row_base_q   <= '0;
      col_stride_q <= '0;
      row_stride_q <= '0;
      col_count_q  <= '0;
      row_count_q  <= '0;
      r_q          <= '0;
      c_q          <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
      row_base_q   <= row_base_d;
      col_stride_q <= col_stride_d;
      row_stride_q <= row_stride_d;
      col_count_q  <= col_count_d;
      row_count_q  <= row_count_d;
      r_q          <= r_d;
      c_q          <= c_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_valid_q && at_last;
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_strided_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_strided_addr_gen                                           |
// | Brief  : Scoreboard bench for strided_addr_gen. Stimulus pushes the    |
// |          address list of each accepted tile; a monitor pops and        |
// |          compares on every transfer and checks done / stall stability. |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_strided_addr_gen;

  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] col_stride = '0;
  logic [AW-1:0] row_stride = '0;
  logic [CW-1:0] col_count = '0;
  logic [CW-1:0] row_count = '0;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          addr_ready = 1'b0;
  logic          addr_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] limit_addr = '1;
`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
  logic          bound_err;
`endif

  strided_addr_gen #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .col_stride (col_stride),
    .row_stride (row_stride),
    .col_count  (col_count),
    .row_count  (row_count),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last),
    .busy       (busy),
    .done       (done)
`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
    ,
    .limit_addr (limit_addr),
    .bound_err  (bound_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    bit l;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the full address list of a tile, straight from the formula.
  task automatic push_tile(input int b, input int cs, input int rs, input int cc, input int rc);
    exp_t e;
    for (int r = 0; r < rc; r++) begin
      for (int c = 0; c < cc; c++) begin
        e.a = (b + r * rs + c * cs) % (1 << AW);
        e.l = (r == rc - 1) && (c == cc - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = 1,0,0 repeating.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: addr_ready = 1'b1;
        1: addr_ready = 1'($urandom_range(0, 1));
        default: begin
          addr_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  // Monitor: transfers against the scoreboard, done timing, stall stability.
  initial begin
    bit       exp_done = 1'b0;
    bit       prev_stall = 1'b0;
    bit       prev_rst = 1'b1;
    bit       xfer;
    int       prev_addr = 0;
    int       prev_last = 0;
    exp_t     e;
    forever begin
      @(negedge clk);
      chk("done", int'(done), int'(exp_done));
      if (prev_stall && !prev_rst) begin
        chk("stall_valid", int'(addr_valid), 1);
        chk("stall_addr", int'(addr), prev_addr);
        chk("stall_last", int'(addr_last), prev_last);
      end
      xfer = addr_valid && addr_ready && !rst;
      if (xfer) begin
        if (sb.size() == 0) begin
          chk("unexpected_addr", int'(addr), -1);
        end else begin
          e = sb.pop_front();
          chk("addr", int'(addr), e.a);
          chk("addr_last", int'(addr_last), int'(e.l));
        end
      end
      exp_done   = !rst && ((xfer && addr_last) ||
                   (start && !busy && (col_count == 0 || row_count == 0)));
      prev_stall = addr_valid && !addr_ready;
      prev_addr  = int'(addr);
      prev_last  = int'(addr_last);
      prev_rst   = rst;
    end
  end

  // Present a tile, hold start until accepted, then check first-cycle response.
  task automatic issue_tile(input int b, input int cs, input int rs, input int cc,
                            input int rc, output bit acc_done);
    int  n = 0;
    bit  nz;
    @(posedge clk);
    #1;
    base_addr  = AW'(b);
    col_stride = AW'(cs);
    row_stride = AW'(rs);
    col_count  = CW'(cc);
    row_count  = CW'(rc);
    start      = 1'b1;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 500) begin
        chk("accept_timeout", n, 0);
        break;
      end
    end
    acc_done = done;
    nz = (cc != 0) && (rc != 0);
    if (nz) push_tile(b, cs, rs, cc, rc);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("first_valid", int'(addr_valid), int'(nz && (b <= int'(limit_addr))));
    if (nz && b <= int'(limit_addr)) chk("first_addr", int'(addr), b);
    if (!nz) chk("zero_done", int'(done), 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc > 1000) begin
        chk("done_timeout", cyc, 0);
        break;
      end
    end
  endtask

  initial begin
    bit acc;
    int cyc;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", int'(addr), 0);
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_last", int'(addr_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
    chk("rst_bound_err", int'(bound_err), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: basic tile at full throughput.
    ready_mode = 0;
    issue_tile(2, 1, 4, 3, 2, acc);
    wait_done(cyc);
    chk("t1_cycles", cyc, 6);

    // T2: same tile under backpressure.
    ready_mode = 2;
    issue_tile(2, 1, 4, 3, 2, acc);
    wait_done(cyc);

    // T3: address wrap-around.
    ready_mode = 0;
    issue_tile(14, 1, 0, 4, 1, acc);
    wait_done(cyc);
    chk("t3_cycles", cyc, 4);

    // T4: zero count produces done only.
    issue_tile(5, 3, 2, 0, 5, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_no_valid", int'(addr_valid), 0);
    end

    // T5a: reset while the third address is presented.
    issue_tile(2, 1, 4, 3, 2, acc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t5_third_addr", int'(addr), 4);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_addr", int'(addr), 0);
    chk("t5_valid", int'(addr_valid), 0);
    chk("t5_last", int'(addr_last), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T5b: start pulsed during RUN with different config is ignored.
    ready_mode = 2;
    issue_tile(2, 1, 4, 3, 2, acc);
    @(posedge clk);
    #1;
    base_addr = 4'd9; col_stride = 4'd5; col_count = 4'd1; row_count = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);

    // Back-to-back tiles: second start accepted in the done cycle.
    ready_mode = 0;
    issue_tile(1, 1, 1, 2, 1, acc);
    issue_tile(7, 2, 3, 2, 2, acc);
    chk("b2b_accept_on_done", int'(acc), 1);
    wait_done(cyc);
    chk("b2b_cycles", cyc, 4);

`ifdef STRIDED_ADDR_GEN_BOUND_CHECK_EN
    // T6: bound violation replaces address 7 with bound_err.
    limit_addr = 4'd6;
    issue_tile(2, 1, 4, 3, 2, acc);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bound_err || n > 100) break;
    end
    chk("t6_bound_err", int'(bound_err), 1);
    chk("t6_valid", int'(addr_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_sb_left", sb.size(), 2);
    sb.delete();
    @(negedge clk);
    chk("t6_pulse_one", int'(bound_err), 0);
    limit_addr = '1;
`endif

    // Randomized tiles, issued back to back, random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 24; t++) begin
      if (t == 5)
        issue_tile(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), 15, 1, acc);
      else
        issue_tile(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 4)), acc);
    end
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
